// File: rtl/rv_div_pkg.sv
// rv_div_pkg: shared constants for the rv_div restoring divider (see rv_div for RV_DIV_SIGNED_EN).
package rv_div_pkg;
    localparam int XLEN_DEF = 64;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int CNT_W = $clog2(XLEN_DEF);

    function automatic int cnt_w(input int xlen);
        return $clog2(xlen);
    endfunction
endpackage

// File: rtl/rv_div_step.sv
// rv_div_step: one combinational restoring-division iteration.
module rv_div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] prem,
    input  logic            msb,
    input  logic [XLEN-1:0] dvs,
    output logic [XLEN-1:0] prem_n,
    output logic            q
);
    logic [XLEN:0] diff;
    // XLEN+1 bits: the shifted remainder can reach twice the divisor
    always_comb begin
        diff   = {prem, msb} - {1'b0, dvs};
        q      = ~diff[XLEN];
        prem_n = q ? diff[XLEN-1:0] : {prem[XLEN-2:0], msb};
    end
endmodule

// File: rtl/rv_div.sv
// rv_div: iterative radix-2 restoring divider, XLEN cycles per divide plus a one-cycle ready pulse.
// Define RV_DIV_SIGNED_EN to add signed_i and signed (RISC-V DIV/REM) semantics.
module rv_div
    import rv_div_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            vld_i,
`ifdef RV_DIV_SIGNED_EN
    input  logic            signed_i,
`endif
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o,
    output logic            ready_o
);
    localparam int CW = cnt_w(XLEN);

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] prem, dvd, dvs, prem_n, qraw, a, b, quo_n, rem_n;
    logic            q, start;

    rv_div_step #(.XLEN(XLEN)) u_step (
        .prem  (prem),
        .msb   (dvd[XLEN-1]),
        .dvs   (dvs),
        .prem_n(prem_n),
        .q     (q)
    );

    assign qraw  = {dvd[XLEN-2:0], q};
    assign start = vld_i & (state == IDLE | state == DONE);

`ifdef RV_DIV_SIGNED_EN
    logic neg_a, neg_b, neg_q, neg_r;
    always_comb begin
        neg_a = signed_i & op1_i[XLEN-1];
        neg_b = signed_i & op2_i[XLEN-1];
        a     = neg_a ? -op1_i : op1_i;
        b     = neg_b ? -op2_i : op2_i;
        quo_n = neg_q ? -qraw : qraw;
        rem_n = neg_r ? -prem_n : prem_n;
    end
    // divide by zero keeps the all-ones quotient regardless of dividend sign
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (start) begin
            neg_q <= (neg_a ^ neg_b) & |op2_i;
            neg_r <= neg_a;
        end
    end
`else
    always_comb begin
        a     = op1_i;
        b     = op2_i;
        quo_n = qraw;
        rem_n = prem_n;
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            prem    <= '0;
            dvd     <= '0;
            dvs     <= '0;
            quo_o   <= '0;
            rem_o   <= '0;
            ready_o <= 1'b0;
        end else begin
            ready_o <= 1'b0;
            if (start) begin
                dvd   <= a;
                dvs   <= b;
                prem  <= '0;
                cnt   <= CW'(XLEN - 1);
                state <= BUSY;
            end else if (state == BUSY) begin
                prem <= prem_n;
                dvd  <= qraw;
                cnt  <= cnt - 1'b1;
                if (cnt == '0) begin
                    state   <= DONE;
                    ready_o <= 1'b1;
                    quo_o   <= quo_n;
                    rem_o   <= rem_n;
                end
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_rv_div.sv
// tb_rv_div: scoreboard bench for rv_div; directed vectors, monitor checks results, latency and hold.
module tb_rv_div;
    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        int          cyc;
        string       name;
    } exp_t;

    logic        clk = 1'b0, rstn = 1'b0, vld = 1'b0;
    logic [63:0] a = '0, b = '0;
    logic [63:0] rem, quo;
    logic        ready;
`ifdef RV_DIV_SIGNED_EN
    logic        sgn = 1'b0;
`endif

    int          cyc = 0, checks = 0, errors = 0;
    logic [63:0] last_q = '0, last_r = '0;
    exp_t        sb[$];

    rv_div #(.XLEN(64)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .vld_i   (vld),
`ifdef RV_DIV_SIGNED_EN
        .signed_i(sgn),
`endif
        .op1_i   (a),
        .op2_i   (b),
        .rem_o   (rem),
        .quo_o   (quo),
        .ready_o (ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", n, act, exp);
        end
    endtask

    // accepted at edge A; ready must be visible at the negedge where cyc == A+64
    task automatic issue(input string n, input logic [63:0] x, input logic [63:0] y,
                         input logic [63:0] eq, input logic [63:0] er);
        @(negedge clk);
        a   = x;
        b   = y;
        vld = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{eq, er, cyc + 64, n});
        vld = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 200; k++) begin
            if (sb.size() == 0) return;
            @(posedge clk);
        end
        checks++;
        errors++;
        $display("FAIL wait_done pending=%0d want=0", sb.size());
        sb.delete();
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_ready got=1 want=0 cyc=%0d", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.name, "_quo"}, quo, e.q);
                    chk({e.name, "_rem"}, rem, e.r);
                    chk({e.name, "_lat"}, 64'(cyc), 64'(e.cyc));
                    last_q = e.q;
                    last_r = e.r;
                end
            end else begin
                chk("hold_quo", quo, last_q);
                chk("hold_rem", rem, last_r);
                if (sb.size() != 0 && cyc > sb[0].cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s_timeout got=no_ready want=ready at cyc %0d", sb[0].name, sb[0].cyc);
                    void'(sb.pop_front());
                end
            end
        end
    end

    logic [63:0] ta[8] = '{64'd100, 64'hFFFFFFFFFFFFFFD3, 64'h1234, 64'hFFFFFFFFFFFFFFFF,
                           64'hFFFFFFFFFFFFFFFF, 64'd7, 64'd1, 64'hDEADBEEF};
    logic [63:0] tb_[8] = '{64'd7, 64'hFFFFFFFFFFFFFFE5, 64'd0, 64'd1,
                           64'h10, 64'd7, 64'd2, 64'h100};
    logic [63:0] tq[8] = '{64'd14, 64'd0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                           64'h0FFFFFFFFFFFFFFF, 64'd1, 64'd0, 64'hDEADBE};
    logic [63:0] tr[8] = '{64'd2, 64'hFFFFFFFFFFFFFFD3, 64'h1234, 64'd0,
                           64'hF, 64'd0, 64'd1, 64'hEF};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_quo", quo, 64'd0);
        chk("rst_rem", rem, 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            issue($sformatf("vec%0d", i), ta[i], tb_[i], tq[i], tr[i]);
            wait_done();
        end

        // back-to-back: vld held high, junk operands during BUSY must be ignored
        @(negedge clk);
        a   = 64'd50;
        b   = 64'd5;
        vld = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{64'd10, 64'd0, cyc + 64, "b2b1"});
        repeat (64) begin
            @(negedge clk);
            a = 64'd999;
            b = 64'd3;
            @(posedge clk);
        end
        @(negedge clk);
        a = 64'd9;
        b = 64'd4;
        @(posedge clk);
        #1;
        sb.push_back('{64'd2, 64'd1, cyc + 64, "b2b2"});
        vld = 1'b0;
        wait_done();

        // reset in the middle of BUSY aborts without a ready pulse
        @(negedge clk);
        a   = 64'd1000;
        b   = 64'd3;
        vld = 1'b1;
        @(posedge clk);
        #1;
        vld = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        rstn   = 1'b0;
        last_q = '0;
        last_r = '0;
        #1;
        chk("abort_ready", 64'(ready), 64'd0);
        chk("abort_quo", quo, 64'd0);
        chk("abort_rem", rem, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        issue("after_rst", 64'd81, 64'd9, 64'd9, 64'd0);
        wait_done();

`ifdef RV_DIV_SIGNED_EN
        sgn = 1'b1;
        issue("s_m7_2", 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFFF);
        wait_done();
        issue("s_ovf", 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 64'd0);
        wait_done();
        issue("s_div0", 64'hFFFFFFFFFFFFFFF9, 64'd0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFF9);
        wait_done();
        issue("s_7_m2", 64'd7, 64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFFFFD, 64'd1);
        wait_done();
        sgn = 1'b0;
        issue("u_big_2", 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'h7FFFFFFFFFFFFFFC, 64'd1);
        wait_done();
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end
endmodule
